// File: rtl/amber48_pkg.sv
// Shared amber48 types and constants used by the register file and its scoreboard.
// The optional read bypass is controlled by AMBER48_RF_BYPASS_EN (see amber48_regfile_sb).
package amber48_pkg;

    localparam int AMBER48_XLEN      = 48;
    localparam int AMBER48_REG_COUNT = 16;
    localparam int AMBER48_RF_AW     = $clog2(AMBER48_REG_COUNT);
    localparam int RF_MAX_RD_PORTS   = 4;

    // Single-port read request, kept for existing users of the older regfile.
    typedef struct packed {
        logic                     re;
        logic [AMBER48_RF_AW-1:0] addr;
    } amber48_regfile_req_s;

    typedef struct packed {
        logic                     we;
        logic [AMBER48_RF_AW-1:0] addr;
        logic [AMBER48_XLEN-1:0]  data;
    } amber48_rf_write_s;

endpackage

// File: rtl/amber48_rf_scoreboard.sv
// Busy-bit scoreboard: tracks registers claimed by long-latency producers.
// Writes clear busy, accepted claims set it; a same-cycle claim wins over the clearing write.
module amber48_rf_scoreboard
    import amber48_pkg::*;
#(
    parameter  int REG_COUNT = AMBER48_REG_COUNT,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_claim_valid,
    input  logic [AW-1:0]        i_claim_rd,
    input  logic                 i_wb_we,
    input  logic [AW-1:0]        i_wb_addr,
    input  logic                 i_ld_we,
    input  logic [AW-1:0]        i_ld_addr,
    input  logic                 i_flush,
    output logic                 o_claim_ready,
    output logic [REG_COUNT-1:0] o_busy_vec
);

    logic [REG_COUNT-1:0] r_busy;
    logic [REG_COUNT-1:0] w_clear;
    logic [REG_COUNT-1:0] w_set;
    logic [REG_COUNT-1:0] w_busy_bypass;
    logic                 w_claim_ready;

    always_comb begin
        w_clear = '0;
        if (i_wb_we) w_clear[i_wb_addr] = 1'b1;
        if (i_ld_we) w_clear[i_ld_addr] = 1'b1;
        w_clear[0] = 1'b0;
    end

    // Claim readiness sees the busy state after this cycle's writes have cleared it.
    assign w_busy_bypass = r_busy & ~w_clear;
    assign w_claim_ready = !i_flush && ((i_claim_rd == '0) || !w_busy_bypass[i_claim_rd]);

    always_comb begin
        w_set = '0;
        if (i_claim_valid && w_claim_ready && (i_claim_rd != '0)) w_set[i_claim_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else if (i_flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_bypass | w_set;
        end
    end

    assign o_claim_ready = w_claim_ready;
    assign o_busy_vec    = r_busy;

endmodule

// File: rtl/amber48_regfile_sb.sv
// amber48 multi-read-port register file with integrated busy scoreboard; R0 is hardwired zero.
// Define AMBER48_RF_BYPASS_EN to forward same-cycle writes to the read ports.
module amber48_regfile_sb
    import amber48_pkg::*;
#(
    parameter  int XLEN         = AMBER48_XLEN,
    parameter  int REG_COUNT    = AMBER48_REG_COUNT,
    parameter  int NUM_RD_PORTS = 2,
    localparam int AW           = $clog2(REG_COUNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr_i,
    output logic [NUM_RD_PORTS*XLEN-1:0] rd_data_o,
    output logic [NUM_RD_PORTS-1:0]      rd_busy_o,
    input  logic                         claim_valid_i,
    input  logic [AW-1:0]                claim_rd_i,
    output logic                         claim_ready_o,
    input  logic                         wb_we_i,
    input  logic [AW-1:0]                wb_addr_i,
    input  logic [XLEN-1:0]              wb_data_i,
    input  logic                         ld_we_i,
    input  logic [AW-1:0]                ld_addr_i,
    input  logic [XLEN-1:0]              ld_data_i,
    input  logic                         flush_i,
    output logic [REG_COUNT-1:0]         busy_vec_o
);

    logic [XLEN-1:0]      r_regs [REG_COUNT];
    logic [REG_COUNT-1:0] w_busy_vec;

    amber48_rf_scoreboard #(.REG_COUNT(REG_COUNT)) u_sb (
        .clk           (clk),
        .rst           (rst),
        .i_claim_valid (claim_valid_i),
        .i_claim_rd    (claim_rd_i),
        .i_wb_we       (wb_we_i),
        .i_wb_addr     (wb_addr_i),
        .i_ld_we       (ld_we_i),
        .i_ld_addr     (ld_addr_i),
        .i_flush       (flush_i),
        .o_claim_ready (claim_ready_o),
        .o_busy_vec    (w_busy_vec)
    );

    // The load port is written last so it wins a same-address collision with writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else begin
            if (wb_we_i && (wb_addr_i != '0)) r_regs[wb_addr_i] <= wb_data_i;
            if (ld_we_i && (ld_addr_i != '0)) r_regs[ld_addr_i] <= ld_data_i;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = rd_addr_i[p*AW +: AW];

        always_comb begin
            w_data = r_regs[w_addr];
            w_busy = w_busy_vec[w_addr];
`ifdef AMBER48_RF_BYPASS_EN
            if (ld_we_i && (ld_addr_i == w_addr)) begin
                w_data = ld_data_i;
                w_busy = 1'b0;
            end else if (wb_we_i && (wb_addr_i == w_addr)) begin
                w_data = wb_data_i;
                w_busy = 1'b0;
            end
`endif
            if (w_addr == '0) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rd_data_o[p*XLEN +: XLEN] = w_data;
        assign rd_busy_o[p]              = w_busy;
    end

    assign busy_vec_o = w_busy_vec;

endmodule

// File: tb/tb_amber48_regfile_sb.sv
// Bench for amber48_regfile_sb: directed scenarios then random traffic against an array model.
// Honours AMBER48_RF_BYPASS_EN so the read expectations follow the built configuration.
module tb_amber48_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [95:0] rd_data;
    logic [1:0]  rd_busy;
    logic        claim_valid;
    logic [3:0]  claim_rd;
    logic        claim_ready;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [47:0] wb_data;
    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [47:0] ld_data;
    logic        flush;
    logic [15:0] busy_vec;

    logic [47:0] m_regs [16];
    bit          m_busy [16];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    amber48_regfile_sb dut (
        .clk           (clk),
        .rst           (rst),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_busy_o     (rd_busy),
        .claim_valid_i (claim_valid),
        .claim_rd_i    (claim_rd),
        .claim_ready_o (claim_ready),
        .wb_we_i       (wb_we),
        .wb_addr_i     (wb_addr),
        .wb_data_i     (wb_data),
        .ld_we_i       (ld_we),
        .ld_addr_i     (ld_addr),
        .ld_data_i     (ld_data),
        .flush_i       (flush),
        .busy_vec_o    (busy_vec)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit written_now(input logic [3:0] r);
        return (r != 0) && ((wb_we && wb_addr == r) || (ld_we && ld_addr == r));
    endfunction

    function automatic bit exp_ready();
        return !flush && (claim_rd == 0 || !m_busy[claim_rd] || written_now(claim_rd));
    endfunction

    function automatic logic [15:0] exp_busy_vec();
        logic [15:0] v;
        for (int r = 0; r < 16; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic drive(input logic [3:0] ra0, input logic [3:0] ra1,
                         input logic cv, input logic [3:0] cr,
                         input logic wbw, input logic [3:0] wba, input logic [47:0] wbd,
                         input logic ldw, input logic [3:0] lda, input logic [47:0] ldd,
                         input logic fl);
        rd_addr = {ra1, ra0};
        claim_valid = cv;  claim_rd = cr;
        wb_we = wbw;  wb_addr = wba;  wb_data = wbd;
        ld_we = ldw;  ld_addr = lda;  ld_data = ldd;
        flush = fl;
    endtask

    task automatic check_comb(input string tag);
        for (int p = 0; p < 2; p++) begin
            logic [3:0]  a;
            logic [47:0] ed;
            logic        eb;
            a  = rd_addr[p*4 +: 4];
            ed = m_regs[a];
            eb = m_busy[a];
`ifdef AMBER48_RF_BYPASS_EN
            if (ld_we && ld_addr == a) begin
                ed = ld_data;  eb = 1'b0;
            end else if (wb_we && wb_addr == a) begin
                ed = wb_data;  eb = 1'b0;
            end
`endif
            if (a == 0) begin
                ed = '0;  eb = 1'b0;
            end
            chk($sformatf("%s/rd_data%0d", tag, p), {16'h0, rd_data[p*48 +: 48]}, {16'h0, ed});
            chk($sformatf("%s/rd_busy%0d", tag, p), {63'h0, rd_busy[p]}, {63'h0, eb});
        end
        chk({tag, "/claim_ready"}, {63'h0, claim_ready}, {63'h0, exp_ready()});
        chk({tag, "/busy_vec"}, {48'h0, busy_vec}, {48'h0, exp_busy_vec()});
    endtask

    task automatic model_update();
        bit accept;
        accept = claim_valid && exp_ready();
        if (wb_we && wb_addr != 0) begin
            m_regs[wb_addr] = wb_data;  m_busy[wb_addr] = 0;
        end
        if (ld_we && ld_addr != 0) begin
            m_regs[ld_addr] = ld_data;  m_busy[ld_addr] = 0;
        end
        if (accept && claim_rd != 0) m_busy[claim_rd] = 1;
        if (flush) for (int r = 0; r < 16; r++) m_busy[r] = 0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) begin
            m_regs[r] = '0;  m_busy[r] = 0;
        end
    endtask

    // Inputs are applied 1ns after a rising edge, checked mid-cycle, and committed to the model at the edge.
    task automatic cycle(input string tag);
        #4;
        check_comb(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state on every register, both ports
        for (int a = 1; a < 16; a++) begin
            drive(4'(a), 4'(16 - a), 0, 0, 0, 0, 0, 0, 0, 0, 0);
            cycle("reset_read");
        end
        drive(0, 0, 0, 0, 1, 3, 48'h1234_5678_9ABC, 0, 0, 0, 0);
        cycle("wr_r3");
        drive(3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rd_r3");
        chk("r3_value", {16'h0, rd_data[47:0]}, 64'h1234_5678_9ABC);

        // R0 stays zero and never becomes busy
        drive(0, 0, 0, 0, 1, 0, 48'hFFFF_FFFF_FFFF, 0, 0, 0, 0);
        cycle("wr_r0");
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("claim_r0");
        chk("r0_value", {16'h0, rd_data[47:0]}, 64'h0);
        chk("r0_not_busy", {48'h0, busy_vec}, 64'h0);

        // Claim, refused re-claim, load return
        drive(5, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        cycle("claim_r5");
        drive(5, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        cycle("reclaim_r5");
        drive(5, 0, 0, 0, 0, 0, 0, 1, 5, 48'hA5, 0);
        cycle("ld_r5");
        drive(5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rd_r5");
        chk("r5_value", {16'h0, rd_data[47:0]}, 64'hA5);

        // Write-port collision and claim/write overlap
        drive(0, 0, 0, 0, 1, 7, 48'h1, 1, 7, 48'h2, 0);
        cycle("wb_ld_r7");
        drive(7, 9, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        cycle("claim_r9");
        chk("r7_value", {16'h0, rd_data[47:0]}, 64'h2);
        drive(9, 7, 1, 9, 0, 0, 0, 1, 9, 48'h99, 0);
        cycle("ld_claim_r9");
        drive(9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rd_r9");
        chk("r9_busy", {48'h0, busy_vec}, 64'h0200);

        // Flush drops busy bits and a same-cycle claim
        drive(2, 4, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        cycle("claim_r2");
        drive(4, 6, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        cycle("claim_r4");
        drive(6, 8, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        cycle("claim_r6");
        drive(8, 2, 1, 8, 0, 0, 0, 0, 0, 0, 1);
        cycle("flush_claim_r8");
        chk("flush_busy_vec", {48'h0, busy_vec}, 64'h0);
        drive(8, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("post_flush");

        // Same-cycle write and read of R10
        drive(10, 10, 0, 0, 1, 10, 48'h77, 0, 0, 0, 0);
        cycle("wb_rd_r10");
        drive(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rd_r10");
        chk("r10_value", {16'h0, rd_data[47:0]}, 64'h77);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(15)), 4'($urandom_range(15)),
                  1'($urandom_range(1)), 4'($urandom_range(15)),
                  1'($urandom_range(1)), 4'($urandom_range(15)), {16'($urandom), 32'($urandom)},
                  1'($urandom_range(1)), 4'($urandom_range(15)), {16'($urandom), 32'($urandom)},
                  ($urandom_range(15) == 0));
            cycle("random");
        end

        // Asynchronous reset in the middle of traffic
        drive(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 1, 3, 1, 4, 48'h55, 1, 5, 48'h66, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_busy_vec", {48'h0, busy_vec}, 64'h0);
        chk("async_rst_rd0", {16'h0, rd_data[47:0]}, 64'h0);
        chk("async_rst_rd1", {16'h0, rd_data[95:48]}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int a = 1; a < 16; a += 2) begin
            drive(4'(a), 4'(a + 1), 0, 0, 0, 0, 0, 0, 0, 0, 0);
            cycle("after_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
